// File: rtl/processor_pkg.sv
// Shared definitions for the dual-core memory arbiter: FSM encoding and core ids.
package processor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic CORE1 = 1'b0;
  localparam logic CORE2 = 1'b1;

  // The core that was not granted last; used to break ties.
  function automatic logic other_core(input logic id);
    return (id == CORE1) ? CORE2 : CORE1;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: picks the requester that was not served last on a tie.
module rr_pick2
  import processor_pkg::*;
(
  input  logic req1,
  input  logic req2,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Decide which core wins this decision edge.
  always_comb begin
    valid  = req1 | req2;
    winner = CORE1;
    if (req1 && req2) begin
      winner = other_core(last_grant);
    end else if (req1) begin
      winner = CORE1;
    end else if (req2) begin
      winner = CORE2;
    end else begin
      winner = CORE1;
    end
  end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Shares one single-port memory between two cores: one access at a time,
// grant pulse in ISSUE, read data returned with a one-cycle valid strobe.
module dual_core_mem_arbiter
  import processor_pkg::*;
#(
  parameter int reg_width   = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req1,
  input  logic                 req2,
  input  logic                 wr1,
  input  logic                 wr2,
  input  logic [reg_width-1:0] addr1,
  input  logic [reg_width-1:0] addr2,
  input  logic [reg_width-1:0] wdata1,
  input  logic [reg_width-1:0] wdata2,
  output logic                 gnt1,
  output logic                 gnt2,
  output logic                 rvalid1,
  output logic                 rvalid2,
  output logic [reg_width-1:0] rdata1,
  output logic [reg_width-1:0] rdata2,
  output logic [reg_width-1:0] mem_address,
  output logic [reg_width-1:0] mem_data,
  output logic                 mem_wren,
  input  logic [reg_width-1:0] mem_q,
  output logic                 busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 wr_q, wr_d;
  logic [reg_width-1:0] addr_q, addr_d;
  logic [reg_width-1:0] wdata_q, wdata_d;
  logic                 last_grant_q, last_grant_d;
  logic                 rvalid1_q, rvalid1_d;
  logic                 rvalid2_q, rvalid2_d;
  logic [reg_width-1:0] rdata1_q, rdata1_d;
  logic [reg_width-1:0] rdata2_q, rdata2_d;

  logic                 pick_valid;
  logic                 pick_id;

  rr_pick2 u_pick (
    .req1       (req1),
    .req2       (req2),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  // Next-state logic: selection/latching in IDLE, issue, latency wait and read return.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    rvalid1_d    = 1'b0;
    rvalid2_d    = 1'b0;
    rdata1_d     = rdata1_q;
    rdata2_d     = rdata2_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ISSUE;
          id_d         = pick_id;
          last_grant_d = pick_id;
          if (pick_id == CORE1) begin
            wr_d    = wr1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            wr_d    = wr2;
            addr_d  = addr2;
            wdata_d = wdata2;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d = {CNT_W{1'b0}};
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
          if (id_q == CORE1) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_q;
          end else begin
            rvalid2_d = 1'b1;
            rdata2_d  = mem_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      id_q         <= CORE1;
      wr_q         <= 1'b0;
      addr_q       <= {reg_width{1'b0}};
      wdata_q      <= {reg_width{1'b0}};
      last_grant_q <= CORE2;
      rvalid1_q    <= 1'b0;
      rvalid2_q    <= 1'b0;
      rdata1_q     <= {reg_width{1'b0}};
      rdata2_q     <= {reg_width{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      rvalid1_q    <= rvalid1_d;
      rvalid2_q    <= rvalid2_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
    end
  end

  // Outputs decode registered state only; memory bus holds the last latched access.
  assign gnt1        = (state_q == ISSUE) && (id_q == CORE1);
  assign gnt2        = (state_q == ISSUE) && (id_q == CORE2);
  assign mem_wren    = (state_q == ISSUE) && wr_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign busy        = (state_q != IDLE);
  assign rvalid1     = rvalid1_q;
  assign rvalid2     = rvalid2_q;
  assign rdata1      = rdata1_q;
  assign rdata2      = rdata2_q;

endmodule

// File: doc/dual_core_mem_arbiter.md
# dual_core_mem_arbiter

Arbitrates the single-port shared data memory (MemoryQ) between the two processor cores. Each core's AR/DR/mem_write/mem_read outputs feed this block. The block forwards one access at a time to memory and returns read data to the requester with a one-cycle valid strobe. It sits between the cores and MemoryQ in the top-level processor and replaces the direct core1-to-memory hookup.

## Interface

Parameters:
- reg_width, 12, address and data width (matches core AR/DR width)
- MEM_LATENCY, 1, cycles from the address sample edge until `mem_q` is valid (legal range 1..3)

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- req1 / req2  in  1  access request from core 1 / core 2; held high until the matching grant
- wr1 / wr2  in  1  1 = write, 0 = read; stable while req is high
- addr1 / addr2  in  reg_width  access address
- wdata1 / wdata2  in  reg_width  write data
- gnt1 / gnt2  out  1  one-cycle grant pulse
- rvalid1 / rvalid2  out  1  one-cycle read-data-valid pulse
- rdata1 / rdata2  out  reg_width  read data; holds the last value delivered to that core
- mem_address  out  reg_width  to MemoryQ address
- mem_data  out  reg_width  to MemoryQ data
- mem_wren  out  1  to MemoryQ wren
- mem_q  in  reg_width  from MemoryQ q
- busy  out  1  high whenever state is not IDLE

## Operation

- FSM states and transitions:
  - IDLE: no access in flight. If any req is sampled at a posedge, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle. A write returns to IDLE. A read goes to WAIT.
  - WAIT: lasts exactly MEM_LATENCY cycles, then returns to IDLE.
- Selection at the IDLE decision edge:
  - Only one req high: select that core.
  - Both req high: select the core that was not granted last (round-robin).
  - `last_grant` updates at every selection.
  - Reset value of `last_grant` = core 2, so core 1 wins the first tie.
- At the selection edge the block latches the winner's id, wr, addr and wdata into internal registers. Later changes on the requester's inputs are ignored.
- During ISSUE:
  - The winner's gnt is high.
  - mem_address and mem_data are driven from the latched registers.
  - mem_wren = latched wr.
- mem_wren is high only in ISSUE and only for a write.
- mem_address and mem_data hold their last latched value outside ISSUE.
- Read return:
  - On the edge that ends the last WAIT cycle, mem_q is captured into the requester's rdata.
  - The requester's rvalid is high for the following cycle, which is an IDLE cycle.
  - The other core's rdata and rvalid are untouched.
- Protocol for the cores:
  - Each core drops req on the edge that ends its gnt cycle.
  - A req still high in IDLE after that is treated as a new request.
  - Changing wr/addr/wdata while req is high and ungranted is a protocol violation; the values sampled at the selection edge are used.
- A losing core keeps req high and is selected at the next IDLE decision edge. No core waits more than one access.
- Reset asserted mid-operation:
  - Immediately forces IDLE and all outputs to their reset values.
  - An in-flight read is discarded and produces no rvalid.

## Timing

- Reset values: gnt1 = gnt2 = 0, rvalid1 = rvalid2 = 0, rdata1 = rdata2 = 0, mem_wren = 0, mem_address = 0, mem_data = 0, busy = 0, state = IDLE.
- All outputs are registered or decoded from registered state only. No combinational path from req/addr to memory.
- Write: req sampled at edge E0, then gnt and mem_wren during cycle 1, then IDLE from cycle 2. Next decision edge is the one ending cycle 2.
- Read (MEM_LATENCY = L): req sampled at E0, then ISSUE in cycle 1, then WAIT in cycles 2..1+L, then rvalid in cycle 2+L.
- Back-to-back reads from alternating cores (L = 1): one access per 3 cycles.

## Structure

- Shared package processor_pkg holds:
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2
  - core id constants: CORE1 = 1'b0, CORE2 = 1'b1
- One sub-module, rr_pick2: a combinational round-robin chooser.
  - Inputs: req1, req2, last_grant.
  - Outputs: valid, winner id.
- The FSM, latency counter (sized for MEM_LATENCY), latch registers and return path live in dual_core_mem_arbiter.

## Test plan

- Reset, then single write: core1 writes 12'h0A5 to address 12'd900.
  - Required: gnt1 and mem_wren high for exactly one cycle, with mem_address = 900 and mem_data = 0A5.
  - Required: no rvalid on either core.
- Single read (L = 1): core2 reads address 900 after the write above.
  - Required: rvalid2 high exactly 3 cycles after the request edge, with rdata2 = 12'h0A5.
  - Required: rdata1 unchanged.
- Simultaneous requests, both raised at the same edge after reset.
  - Required grant order: core1 then core2.
  - Repeat with both raised again: grants alternate. No core is granted twice while the other is waiting.
- Input change after selection: core1 changes addr from 5 to 7 during its ISSUE cycle.
  - Required: mem_address = 5 throughout the access.
- Reset asserted during WAIT of a core1 read.
  - Required: rvalid1 never pulses and all outputs go to reset values at once.
  - Required: after release, the first tie is granted to core1.
- MEM_LATENCY = 3 read.
  - Required: rvalid exactly 5 cycles after the request edge and busy high for 4 cycles, with rdata equal to memory contents.
